// File: rtl/bp_mem_resp_steer.sv
// Memory response steering: per-destination round-robin arbitration from the
// response sources into a 2-entry FIFO per LCE, with out-of-range lce_id drops.

module bp_mem_resp_steer_chk #(
  parameter int num_src_p = 3,
  parameter int num_dst_p = 2
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  input logic [num_src_p-1:0] src_v_i,
  input logic [num_src_p-1:0] src_yumi_o,
  input logic [num_dst_p-1:0] dst_v_o,
  input logic [num_dst_p-1:0] dst_yumi_i
);

  a_deq_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (dst_yumi_i & ~dst_v_o) == {num_dst_p{1'b0}});

  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (src_yumi_o & ~src_v_i) == {num_src_p{1'b0}});

endmodule

module bp_mem_resp_steer #(
  parameter int num_src_p      = 3,
  parameter int num_dst_p      = 2,
  parameter int msg_width_p    = 16,
  parameter int lce_id_lsb_p   = 0,
  parameter int lce_id_width_p = 2
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_src_p*msg_width_p-1:0] src_data_i,
  input  logic [num_src_p-1:0]             src_v_i,
  output logic [num_src_p-1:0]             src_yumi_o,
  output logic [num_dst_p*msg_width_p-1:0] dst_data_o,
  output logic [num_dst_p-1:0]             dst_v_o,
  input  logic [num_dst_p-1:0]             dst_yumi_i,
  output logic                             drop_o,
  output logic [7:0]                       drop_count_o
);

  localparam int ptr_w = (num_src_p > 1) ? $clog2(num_src_p) : 1;

  logic [msg_width_p-1:0]    msg_s       [num_src_p];
  logic [lce_id_width_p-1:0] dest_s      [num_src_p];
  logic [num_src_p-1:0]      drop_v_s;
  logic [num_src_p-1:0]      yumi_s;
  logic [num_src_p-1:0]      grant_s     [num_dst_p];
  logic [ptr_w-1:0]          grant_idx_s [num_dst_p];
  logic [msg_width_p-1:0]    enq_data_s  [num_dst_p];
  logic [num_dst_p-1:0]      enq_s;
  logic [num_dst_p-1:0]      deq_s;
  logic [num_dst_p-1:0]      valid_s;
  logic [8:0]                drop_sum_s;
  logic [7:0]                drop_next_s;

  logic [ptr_w-1:0]          last_r  [num_dst_p];
  logic [1:0]                count_r [num_dst_p];
  logic [msg_width_p-1:0]    head_r  [num_dst_p];
  logic [msg_width_p-1:0]    tail_r  [num_dst_p];
  logic                      drop_r;
  logic [7:0]                drop_count_r;

  // Split the source bus and flag messages whose lce_id has no destination
  always_comb begin
    for (int i = 0; i < num_src_p; i++) begin
      msg_s[i]    = src_data_i[i*msg_width_p +: msg_width_p];
      dest_s[i]   = msg_s[i][lce_id_lsb_p +: lce_id_width_p];
      drop_v_s[i] = src_v_i[i] && (int'(dest_s[i]) >= num_dst_p);
    end
  end

  // Round-robin arbitration per destination, starting after the last grant
  always_comb begin
    int   idx;
    logic hit;
    idx = 0;
    hit = 1'b0;
    for (int d = 0; d < num_dst_p; d++) begin
      grant_s[d]     = {num_src_p{1'b0}};
      grant_idx_s[d] = last_r[d];
      enq_data_s[d]  = head_r[d];
      enq_s[d]       = 1'b0;
      for (int k = 0; k < num_src_p; k++) begin
        idx = (int'(last_r[d]) + 1 + k) % num_src_p;
        hit = !enq_s[d] && (count_r[d] != 2'd2) && reset_n_i &&
              src_v_i[idx] && (int'(dest_s[idx]) == d);
        grant_s[d][idx] = hit;
        grant_idx_s[d]  = hit ? ptr_w'(idx) : grant_idx_s[d];
        enq_data_s[d]   = hit ? msg_s[idx] : enq_data_s[d];
        enq_s[d]        = enq_s[d] | hit;
      end
    end
  end

  // Merge grants and drops into the per-source yumi; FIFO heads drive outputs
  always_comb begin
    yumi_s = drop_v_s & {num_src_p{reset_n_i}};
    for (int d = 0; d < num_dst_p; d++) begin
      yumi_s = yumi_s | grant_s[d];
      valid_s[d] = (count_r[d] != 2'd0);
      dst_data_o[d*msg_width_p +: msg_width_p] = head_r[d];
    end
    deq_s       = dst_yumi_i & valid_s;
    drop_sum_s  = {1'b0, drop_count_r} + 9'($countones(drop_v_s));
    drop_next_s = (drop_sum_s > 9'd255) ? 8'd255 : drop_sum_s[7:0];
  end

  assign src_yumi_o   = yumi_s;
  assign dst_v_o      = valid_s;
  assign drop_o       = drop_r;
  assign drop_count_o = drop_count_r;

  // Destination FIFOs (head/tail shift pair) and round-robin pointers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int d = 0; d < num_dst_p; d++) begin
        last_r[d]  <= ptr_w'(num_src_p - 1);
        count_r[d] <= 2'd0;
        head_r[d]  <= {msg_width_p{1'b0}};
        tail_r[d]  <= {msg_width_p{1'b0}};
      end
    end else begin
      for (int d = 0; d < num_dst_p; d++) begin
        last_r[d] <= enq_s[d] ? grant_idx_s[d] : last_r[d];
        case ({enq_s[d], deq_s[d]})
          2'b10: begin
            if (count_r[d] == 2'd0) begin
              head_r[d] <= enq_data_s[d];
            end else begin
              tail_r[d] <= enq_data_s[d];
            end
            count_r[d] <= count_r[d] + 2'd1;
          end
          2'b01: begin
            head_r[d]  <= tail_r[d];
            count_r[d] <= count_r[d] - 2'd1;
          end
          // Enq only happens below full, so a concurrent deq means count is 1
          2'b11:   head_r[d]  <= enq_data_s[d];
          default: count_r[d] <= count_r[d];
        endcase
      end
    end
  end

  // Drop pulse and saturating drop counter
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      drop_r       <= 1'b0;
      drop_count_r <= 8'd0;
    end else begin
      drop_r       <= |drop_v_s;
      drop_count_r <= drop_next_s;
    end
  end

  bp_mem_resp_steer_chk #(
    .num_src_p (num_src_p),
    .num_dst_p (num_dst_p)
  ) u_chk (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .src_v_i    (src_v_i),
    .src_yumi_o (yumi_s),
    .dst_v_o    (valid_s),
    .dst_yumi_i (dst_yumi_i)
  );

endmodule

// File: tb/tb_bp_mem_resp_steer.sv
// Randomized bench for bp_mem_resp_steer against a queue-based reference model.

module tb_bp_mem_resp_steer;

  localparam int NS = 3;
  localparam int ND = 2;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS*W-1:0] src_data;
  logic [NS-1:0] src_v;
  logic [NS-1:0] src_yumi;
  logic [ND*W-1:0] dst_data;
  logic [ND-1:0] dst_v;
  logic [ND-1:0] dst_yumi;
  logic          drop;
  logic [7:0]    drop_count;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] q [ND][$];
  int           last [ND];
  int           exp_cnt;
  bit           exp_drop;
  bit           pend_v [NS];
  logic [W-1:0] pend_d [NS];

  always #5 clk = ~clk;

  bp_mem_resp_steer #(
    .num_src_p      (NS),
    .num_dst_p      (ND),
    .msg_width_p    (W),
    .lce_id_lsb_p   (0),
    .lce_id_width_p (2)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (rst_n),
    .src_data_i   (src_data),
    .src_v_i      (src_v),
    .src_yumi_o   (src_yumi),
    .dst_data_o   (dst_data),
    .dst_v_o      (dst_v),
    .dst_yumi_i   (dst_yumi),
    .drop_o       (drop),
    .drop_count_o (drop_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      q[d].delete();
      last[d] = NS - 1;
    end
    exp_cnt  = 0;
    exp_drop = 1'b0;
  endtask

  // One clock of traffic: p_new = % chance an idle source offers a message,
  // p_yumi = % chance a non-empty destination consumes, p_far = % out-of-range
  task automatic run_cycle(input int p_new, input int p_yumi, input int p_far);
    logic [NS-1:0] exp_yumi;
    int            gsrc [ND];
    int            ndrop;
    int            lce;
    int            s;
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      if (!pend_v[i] && $urandom_range(99, 0) < p_new) begin
        lce = ($urandom_range(99, 0) < p_far) ? $urandom_range(3, 2) : $urandom_range(1, 0);
        pend_d[i] = W'($urandom);
        pend_d[i][1:0] = 2'(lce);
        pend_v[i] = 1'b1;
      end
      src_v[i] = pend_v[i];
      src_data[i*W +: W] = pend_d[i];
    end
    for (int d = 0; d < ND; d++)
      dst_yumi[d] = (q[d].size() > 0) && ($urandom_range(99, 0) < p_yumi);
    #1;
    exp_yumi = '0;
    ndrop = 0;
    for (int i = 0; i < NS; i++) begin
      if (pend_v[i] && int'(pend_d[i][1:0]) >= ND) begin
        exp_yumi[i] = 1'b1;
        ndrop++;
      end
    end
    for (int d = 0; d < ND; d++) begin
      gsrc[d] = -1;
      if (q[d].size() < 2) begin
        for (int k = 1; k <= NS; k++) begin
          s = (last[d] + k) % NS;
          if (gsrc[d] < 0 && pend_v[s] && int'(pend_d[s][1:0]) == d) gsrc[d] = s;
        end
      end
      if (gsrc[d] >= 0) exp_yumi[gsrc[d]] = 1'b1;
    end
    check("src_yumi", 32'(src_yumi), 32'(exp_yumi));
    for (int d = 0; d < ND; d++) begin
      check($sformatf("dst_v%0d", d), 32'(dst_v[d]), 32'(q[d].size() > 0));
      if (q[d].size() > 0)
        check($sformatf("dst_data%0d", d), 32'(dst_data[d*W +: W]), 32'(q[d][0]));
    end
    check("drop", 32'(drop), 32'(exp_drop));
    check("drop_count", 32'(drop_count), 32'(exp_cnt));
    for (int d = 0; d < ND; d++) begin
      if (dst_yumi[d]) void'(q[d].pop_front());
      if (gsrc[d] >= 0) begin
        q[d].push_back(pend_d[gsrc[d]]);
        last[d] = gsrc[d];
      end
    end
    exp_drop = (ndrop > 0);
    exp_cnt  = (exp_cnt + ndrop > 255) ? 255 : exp_cnt + ndrop;
    for (int i = 0; i < NS; i++)
      if (exp_yumi[i]) pend_v[i] = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    src_v    = '0;
    src_data = '0;
    dst_yumi = '0;
    for (int i = 0; i < NS; i++) begin
      pend_v[i] = 1'b0;
      pend_d[i] = '0;
    end
    model_reset();
    #12;
    src_v = 3'b111;
    #1;
    check("rst_dst_v", 32'(dst_v), 32'd0);
    check("rst_src_yumi", 32'(src_yumi), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    src_v = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // single pass: src2 -> lce 1
    pend_v[2] = 1'b1;
    pend_d[2] = 16'h1231;
    for (int c = 0; c < 3; c++) run_cycle(0, 100, 0);

    // random traffic, alternating heavy and light backpressure
    for (int ph = 0; ph < 8; ph++)
      for (int c = 0; c < 250; c++)
        run_cycle(60, (ph % 2 == 1) ? 90 : 15, 20);

    // drop saturation: src0 sends lce 3 repeatedly
    for (int c = 0; c < 300; c++) begin
      pend_v[0] = 1'b1;
      pend_d[0] = 16'h0003;
      run_cycle(0, 50, 0);
    end
    run_cycle(0, 50, 0);
    check("drop_sat", 32'(drop_count), 32'd255);

    // fill both FIFOs, then reset asynchronously between edges
    for (int c = 0; c < 12; c++) run_cycle(100, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_dst_v", 32'(dst_v), 32'd0);
    check("midrst_src_yumi", 32'(src_yumi), 32'd0);
    check("midrst_drop_count", 32'(drop_count), 32'd0);
    src_v    = '0;
    dst_yumi = '0;
    model_reset();
    for (int i = 0; i < NS; i++) pend_v[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // round robin from src0 after reset
    pend_v[0] = 1'b1; pend_d[0] = 16'hA000;
    pend_v[1] = 1'b1; pend_d[1] = 16'hB000;
    pend_v[2] = 1'b1; pend_d[2] = 16'hC000;
    run_cycle(0, 100, 0);
    check("rr_first", 32'(src_yumi), 32'h1);
    for (int c = 0; c < 4; c++) run_cycle(0, 100, 0);
    for (int c = 0; c < 40; c++) run_cycle(100, 100, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
